// File: rtl/memory_access.sv
// memory_access: RISC-V MEM stage - data memory req/ack handshake, lane steering, branch resolve.
// Optional misaligned-access trap enabled by MEM_MISALIGN_CHECK_EN.
module memory_access #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] branch_addr,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero,
  input  logic [XLEN-1:0] rd2,
  input  logic [4:0]      write_reg_in,
  input  logic [2:0]      funct3,
  input  logic            mem_read_ctrl_in,
  input  logic            mem_write_ctrl_in,
  input  logic            mem_to_reg_ctrl_in,
  input  logic            reg_write_ctrl_in,
  input  logic            branch_ctrl_in,
  input  logic            uncond_branch_ctrl_in,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_ack,
  output logic            stall_out,
  output logic            pc_src,
  output logic [XLEN-1:0] branch_target,
  output logic            flush_pipe,
  output logic [XLEN-1:0] read_data_out,
  output logic [XLEN-1:0] alu_result_out,
  output logic [4:0]      write_reg_out,
  output logic            mem_to_reg_ctrl_out,
  output logic            reg_write_ctrl_out,
  output logic            misalign_err
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state_q, state_d;
  logic mem_op, mis, bubble, cond, taken;
  logic [7:0] byte_sel;
  logic [15:0] half_sel;
  logic [XLEN-1:0] ext;
  logic [XLEN-1:0] read_data_q, read_data_d, alu_result_q, alu_result_d;
  logic [4:0] write_reg_q, write_reg_d;
  logic mem_to_reg_q, mem_to_reg_d, reg_write_q, reg_write_d, misalign_q, misalign_d;
  assign mem_op = mem_read_ctrl_in | mem_write_ctrl_in;
`ifdef MEM_MISALIGN_CHECK_EN
  assign mis = mem_op & ((funct3[1:0] == 2'b01 & alu_result[0]) |
                         (funct3 == 3'b010 & |alu_result[1:0]));
`else
  assign mis = 1'b0;
`endif
  // reset gates the request so an abandoned access drops at once
  assign dmem_req  = reset & (state_q == WAIT | (mem_op & ~mis));
  assign stall_out = dmem_req & ~dmem_ack;
  assign dmem_we   = mem_write_ctrl_in;
  assign dmem_addr = {alu_result[XLEN-1:2], 2'b00};
  assign cond  = (funct3[2] | ~funct3[1]) & (alu_zero ^ funct3[0] ^ funct3[2]);
  assign taken = uncond_branch_ctrl_in | (branch_ctrl_in & cond);
  assign pc_src        = taken & ~stall_out;
  assign flush_pipe    = pc_src;
  assign branch_target = branch_addr;
  assign byte_sel = 8'(dmem_rdata >> {alu_result[1:0], 3'b000});
  assign half_sel = alu_result[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
  always_comb begin
    state_d      = stall_out ? WAIT : IDLE;
    ext          = funct3 == 3'b000 ? {{(XLEN-8){byte_sel[7]}}, byte_sel} :
                   funct3 == 3'b001 ? {{(XLEN-16){half_sel[15]}}, half_sel} :
                   funct3 == 3'b010 ? dmem_rdata :
                   funct3 == 3'b100 ? {{(XLEN-8){1'b0}}, byte_sel} :
                   funct3 == 3'b101 ? {{(XLEN-16){1'b0}}, half_sel} : '0;
    dmem_wdata   = funct3 == 3'b000 ? {4{rd2[7:0]}} :
                   funct3 == 3'b001 ? {2{rd2[15:0]}} : rd2;
    dmem_be      = 4'b0000;
    if (mem_write_ctrl_in & dmem_req)
      dmem_be = funct3 == 3'b000 ? 4'b0001 << alu_result[1:0] :
                funct3 == 3'b001 ? 4'b0011 << {alu_result[1], 1'b0} :
                funct3 == 3'b010 ? 4'b1111 : 4'b0000;
    bubble       = stall_out | mis;
    read_data_d  = (mem_read_ctrl_in & dmem_req & dmem_ack) ? ext : read_data_q;
    alu_result_d = stall_out ? alu_result_q : alu_result;
    write_reg_d  = bubble ? 5'd0 : write_reg_in;
    mem_to_reg_d = mem_to_reg_ctrl_in & ~bubble;
    reg_write_d  = reg_write_ctrl_in & ~bubble;
    misalign_d   = mis;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      read_data_q  <= '0;
      alu_result_q <= '0;
      write_reg_q  <= '0;
      mem_to_reg_q <= 1'b0;
      reg_write_q  <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      read_data_q  <= read_data_d;
      alu_result_q <= alu_result_d;
      write_reg_q  <= write_reg_d;
      mem_to_reg_q <= mem_to_reg_d;
      reg_write_q  <= reg_write_d;
      misalign_q   <= misalign_d;
    end
  end
  assign read_data_out       = read_data_q;
  assign alu_result_out      = alu_result_q;
  assign write_reg_out       = write_reg_q;
  assign mem_to_reg_ctrl_out = mem_to_reg_q;
  assign reg_write_ctrl_out  = reg_write_q;
  assign misalign_err        = misalign_q;
endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access: randomized + directed checks of memory_access against a behavioural model.
module tb_memory_access;
  logic clk = 1'b0, reset = 1'b0;
  logic [31:0] branch_addr = '0, alu_result = '0, rd2 = '0, dmem_rdata = '0;
  logic alu_zero = 1'b0, dmem_ack = 1'b0;
  logic [4:0] write_reg_in = '0;
  logic [2:0] funct3 = '0;
  logic mem_read_ctrl_in = 0, mem_write_ctrl_in = 0, mem_to_reg_ctrl_in = 0;
  logic reg_write_ctrl_in = 0, branch_ctrl_in = 0, uncond_branch_ctrl_in = 0;
  logic dmem_req, dmem_we, stall_out, pc_src, flush_pipe;
  logic [31:0] dmem_addr, dmem_wdata, branch_target, read_data_out, alu_result_out;
  logic [3:0] dmem_be;
  logic [4:0] write_reg_out;
  logic mem_to_reg_ctrl_out, reg_write_ctrl_out, misalign_err;
  int n_tests = 0, n_fail = 0;
  logic [31:0] exp_rd = '0;
`ifdef MEM_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  memory_access dut (
    .clk(clk), .reset(reset), .branch_addr(branch_addr), .alu_result(alu_result),
    .alu_zero(alu_zero), .rd2(rd2), .write_reg_in(write_reg_in), .funct3(funct3),
    .mem_read_ctrl_in(mem_read_ctrl_in), .mem_write_ctrl_in(mem_write_ctrl_in),
    .mem_to_reg_ctrl_in(mem_to_reg_ctrl_in), .reg_write_ctrl_in(reg_write_ctrl_in),
    .branch_ctrl_in(branch_ctrl_in), .uncond_branch_ctrl_in(uncond_branch_ctrl_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .stall_out(stall_out),
    .pc_src(pc_src), .branch_target(branch_target), .flush_pipe(flush_pipe),
    .read_data_out(read_data_out), .alu_result_out(alu_result_out),
    .write_reg_out(write_reg_out), .mem_to_reg_ctrl_out(mem_to_reg_ctrl_out),
    .reg_write_ctrl_out(reg_write_ctrl_out), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic bcond(input logic [2:0] f, input logic z);
    case (f)
      3'd0, 3'd5, 3'd7: return z;
      3'd1, 3'd4, 3'd6: return !z;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ld_model(input logic [2:0] f, input logic [31:0] w, input logic [31:0] a);
    logic [31:0] b, h;
    b = (w >> (8 * a[1:0])) & 32'hFF;
    h = (w >> (16 * a[1])) & 32'hFFFF;
    case (f)
      3'd0: return b >= 128 ? b + 32'hFFFFFF00 : b;
      3'd1: return h >= 32768 ? h + 32'hFFFF0000 : h;
      3'd2: return w;
      3'd4: return b;
      3'd5: return h;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] f, input logic [31:0] a);
    return ((f == 3'd1 || f == 3'd5) && a[0]) || (f == 3'd2 && a[1:0] != 2'b00);
  endfunction

  task automatic run_op(input logic rd, input logic wr, input logic br, input logic jmp,
                        input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] sd,
                        input logic [31:0] baddr, input logic z, input logic [4:0] wreg,
                        input int lat, input logic [31:0] rdata);
    logic mop, m, req_e, stall_e, tk;
    logic [31:0] be_e, wd_e;
    int off;
    @(negedge clk);
    mem_read_ctrl_in = rd; mem_write_ctrl_in = wr; mem_to_reg_ctrl_in = rd;
    reg_write_ctrl_in = rd | jmp | !(wr | br); branch_ctrl_in = br; uncond_branch_ctrl_in = jmp;
    funct3 = f3; alu_result = alu; rd2 = sd; branch_addr = baddr; alu_zero = z; write_reg_in = wreg;
    mop = rd | wr;
    m = MIS_EN && mop && misaligned(f3, alu);
    req_e = mop && !m;
    off = int'(alu[1:0]);
    be_e = !(wr && req_e) ? 0 : f3 == 3'd0 ? 1 << off : f3 == 3'd1 ? 3 << (2 * (off / 2)) :
           f3 == 3'd2 ? 15 : 0;
    wd_e = f3 == 3'd0 ? (sd & 32'hFF) * 32'h01010101 :
           f3 == 3'd1 ? (sd & 32'hFFFF) * 32'h00010001 : sd;
    tk = jmp | (br & bcond(f3, z));
    for (int k = 0; k < 8; k++) begin
      stall_e = req_e && k < lat;
      dmem_ack = req_e && k == lat;
      dmem_rdata = rdata;
      #1;
      check("req", 32'(dmem_req), 32'(req_e));
      check("stall", 32'(stall_out), 32'(stall_e));
      check("pc_src", 32'(pc_src), 32'(tk && !stall_e));
      check("flush", 32'(flush_pipe), 32'(tk && !stall_e));
      check("target", branch_target, baddr);
      check("be", 32'(dmem_be), be_e);
      if (mop) check("addr", dmem_addr, {alu[31:2], 2'b00});
      if (wr) check("we", 32'(dmem_we), 32'd1);
      if (wr) check("wdata", dmem_wdata, wd_e);
      @(posedge clk);
      #1;
      if (stall_e) begin
        check("bub_rw", 32'(reg_write_ctrl_out), 32'd0);
        check("bub_m2r", 32'(mem_to_reg_ctrl_out), 32'd0);
        check("bub_wreg", 32'(write_reg_out), 32'd0);
      end else begin
        if (rd && req_e) exp_rd = ld_model(f3, rdata, alu);
        check("rdata", read_data_out, exp_rd);
        check("alu_out", alu_result_out, alu);
        check("wreg", 32'(write_reg_out), m ? 32'd0 : 32'(wreg));
        check("rw", 32'(reg_write_ctrl_out), 32'((rd | jmp | !(wr | br)) && !m));
        check("m2r", 32'(mem_to_reg_ctrl_out), 32'(rd && !m));
        check("misalign", 32'(misalign_err), 32'(m));
        break;
      end
      @(negedge clk);
    end
    dmem_ack = 1'b0;
  endtask

  task automatic check_regs_zero(input string tag);
    check({tag, "_rd"}, read_data_out, 32'd0);
    check({tag, "_alu"}, alu_result_out, 32'd0);
    check({tag, "_wreg"}, 32'(write_reg_out), 32'd0);
    check({tag, "_ctl"}, {29'd0, mem_to_reg_ctrl_out, reg_write_ctrl_out, misalign_err}, 32'd0);
    check({tag, "_req"}, 32'(dmem_req), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 check_regs_zero("rst");
    @(negedge clk) reset = 1'b1;
    // directed cases
    run_op(1, 0, 0, 0, 3'd2, 32'h100, 0, 0, 0, 5'd3, 0, 32'hDEADBEEF);
    check("lw_data", read_data_out, 32'hDEADBEEF);
    run_op(1, 0, 0, 0, 3'd0, 32'h103, 0, 0, 0, 5'd4, 3, 32'h80FFFFFF);
    check("lb_sext", read_data_out, 32'hFFFFFF80);
    run_op(1, 0, 0, 0, 3'd4, 32'h103, 0, 0, 0, 5'd4, 3, 32'h80FFFFFF);
    check("lbu_zext", read_data_out, 32'h00000080);
    run_op(0, 1, 0, 0, 3'd1, 32'h102, 32'h1234ABCD, 0, 0, 5'd0, 2, 0);
    run_op(0, 0, 1, 0, 3'd1, 32'h0, 0, 32'h40, 0, 5'd0, 0, 0);
    run_op(0, 0, 1, 0, 3'd0, 32'h0, 0, 32'h40, 0, 5'd0, 0, 0);
    run_op(1, 0, 0, 0, 3'd2, 32'h101, 0, 0, 0, 5'd7, 1, 32'h01234567);
    // reset asserted while an access sits in WAIT
    @(negedge clk);
    mem_read_ctrl_in = 1; reg_write_ctrl_in = 1; mem_to_reg_ctrl_in = 1; branch_ctrl_in = 0;
    uncond_branch_ctrl_in = 0; funct3 = 3'd2; alu_result = 32'h200; write_reg_in = 5'd9;
    @(negedge clk);
    #1 check("wait_stall", 32'(stall_out), 32'd1);
    #1 reset = 1'b0;
    #1 check_regs_zero("arst");
    mem_read_ctrl_in = 0; reg_write_ctrl_in = 0; mem_to_reg_ctrl_in = 0;
    exp_rd = '0;
    @(negedge clk) reset = 1'b1;
    #1 check("post_rst_req", 32'(dmem_req), 32'd0);
    // randomized traffic
    for (int i = 0; i < 150; i++) begin
      int kind;
      logic br, f;
      kind = $urandom_range(0, 3);
      br = $urandom_range(0, 1);
      f = $urandom_range(0, 1);
      run_op(kind == 0, kind == 1, kind == 2 && br, kind == 2 && !br,
             kind == 1 ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7)),
             f ? $urandom & 32'h3F : $urandom, $urandom, $urandom,
             1'($urandom_range(0, 1)), 5'($urandom), $urandom_range(0, 3), $urandom);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/memory_access.md
Name: memory_access

Overview:
- MEM stage of the 5-stage RISC-V pipeline. Sits directly downstream of the EX stage and consumes its EX->MEM pipeline registers.
- Issues loads and stores to data memory over a req/ack handshake. Performs byte/half/word lane steering with sign or zero extension.
- Resolves branches: drives pc_src and flush_pipe.
- Produces the MEM->WB pipeline registers and a stall to freeze upstream stages while a memory access is outstanding.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- branch_addr  in  32  branch/jump target from EX
- alu_result  in  32  address, or result to write back
- alu_zero  in  1  ALU zero flag
- rd2  in  32  store data (already forwarded)
- write_reg_in  in  5  destination register
- funct3  in  3  access size / branch condition
- mem_read_ctrl_in, mem_write_ctrl_in, mem_to_reg_ctrl_in, reg_write_ctrl_in, branch_ctrl_in, uncond_branch_ctrl_in  in  1 each  control from EX
- dmem_req  out  1  access request
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word address, {alu_result[31:2],2'b00}
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_rdata  in  32  read word
- dmem_ack  in  1  access complete (may arrive the same cycle as req)
- stall_out  out  1  freeze PC/IF/ID/EX
- pc_src  out  1  select branch_target for the next PC
- branch_target  out  32  equals branch_addr
- flush_pipe  out  1  flush IF/ID/EX
- read_data_out  out  32  registered, extended load data
- alu_result_out  out  32  registered
- write_reg_out  out  5  registered
- mem_to_reg_ctrl_out, reg_write_ctrl_out  out  1 each  registered
- misalign_err  out  1  registered one-cycle pulse

Behaviour:
- Reset: the async low assertion forces state=IDLE. All registered outputs go to 0. dmem_req=0 immediately, including mid-WAIT; the access is abandoned.
- mem_op = mem_read_ctrl_in | mem_write_ctrl_in.
- FSM, two states: IDLE and WAIT.
  - IDLE, no mem_op: no request.
  - IDLE, mem_op: dmem_req=1 combinationally.
    - dmem_ack=1 in the same cycle: complete, stay in IDLE (zero stall).
    - Otherwise: go to WAIT.
  - WAIT: dmem_req stays at 1. Address, data and byte enables are held stable, because inputs are frozen by the stall. On dmem_ack: complete, go to IDLE.
- stall_out = dmem_req & ~dmem_ack.
- MEM->WB registers update every cycle when stall_out=0. While stalled they load a bubble: reg_write_ctrl_out=0, mem_to_reg_ctrl_out=0, write_reg_out=0.
- Loads, by funct3, with lane selected by alu_result[1:0]:
  - 000 LB: sign-extend byte.
  - 001 LH: sign-extend half, lane from addr[1].
  - 010 LW: full word.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend half.
  - Other funct3 values: read_data_out = 0.
  - Extended data is captured into read_data_out on completion.
- Stores:
  - SB 000: dmem_wdata = {4{rd2[7:0]}}, dmem_be = 0001 << addr[1:0].
  - SH 001: dmem_wdata = {2{rd2[15:0]}}, dmem_be = 0011 << {addr[1],1'b0}.
  - SW 010: dmem_wdata = rd2, dmem_be = 1111.
  - dmem_we = mem_write_ctrl_in. dmem_be = 0000 whenever no store is in progress.
- Branch resolution (combinational):
  - taken = uncond_branch_ctrl_in | (branch_ctrl_in & cond).
  - cond by funct3:
    - 000 (BEQ): alu_zero.
    - 001 (BNE): ~alu_zero.
    - 100/110 (BLT/BLTU, ALU computes SLT/SLTU): ~alu_zero.
    - 101/111 (BGE/BGEU): alu_zero.
    - 010/011: 0.
  - pc_src = flush_pipe = taken & ~stall_out.
- Branch and memory operations are mutually exclusive per instruction. If both are asserted, the memory access proceeds and taken still applies after completion.
- Jumps write back alu_result (PC+4) through alu_result_out.

Optional Feature:
- Macro MEM_MISALIGN_CHECK_EN.
- Defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, raises no dmem_req and causes no stall. The next cycle has misalign_err=1 and a MEM->WB bubble (reg_write_ctrl_out=0).
- Undefined: misalign_err is tied to 0. Low address bits are ignored where illegal: a word access aligns down, and a half access uses addr[1] only.

Test Plan:
- LW at 0x100, ack in the same cycle as req: stall_out never asserts. Next cycle read_data_out = dmem_rdata = 0xDEADBEEF and reg_write_ctrl_out=1.
- LB at 0x103, rdata 0x80FF_FFFF, ack after 3 cycles: stall_out=1 for 3 cycles with WB bubbles. Then read_data_out=0xFFFFFF80. LBU of the same access gives 0x00000080.
- SH at 0x102, rd2=0x1234ABCD: dmem_we=1, dmem_be=1100, dmem_wdata=0xABCDABCD, held stable through a 2-cycle WAIT.
- BNE with alu_zero=0, branch_addr=0x40: pc_src=1, flush_pipe=1, branch_target=0x40. BEQ with alu_zero=0: pc_src=0.
- Reset asserted low while in WAIT: dmem_req drops to 0 asynchronously and all outputs read 0. After release, the FSM is in IDLE with no request.
- With MEM_MISALIGN_CHECK_EN, LW at 0x101: no dmem_req, misalign_err pulses 1 cycle, reg_write_ctrl_out=0.
